// File: rtl/debug_pkg.sv
// Shared types and constants for the register-file debug dumper.
//   dbg_state_e        : dump sequencer states
//   DBG_NUM_REGS       : default number of architectural registers dumped
//   DBG_DATA_W         : default register width (multiple of 8)
//   DBG_BYTES_PER_REG  : bytes streamed per register at the default width
package debug_pkg;

    localparam int DBG_NUM_REGS      = 32;
    localparam int DBG_DATA_W        = 32;
    localparam int DBG_BYTES_PER_REG = DBG_DATA_W / 8;

    typedef enum logic [2:0] {
        IDLE,
        SET_ADDR,
        WAIT_RD,
        LOAD,
        SEND,
        CKSUM,
        DONE
    } dbg_state_e;

endpackage

// File: rtl/dbg_byte_serializer.sv
// Splits one DATA_W word into bytes, MSB byte first.
//   clk, rst   : system clock, asynchronous active-high reset
//   load_i     : capture data_i and arm the byte counter
//   data_i     : word to serialize
//   shift_i    : current byte accepted downstream; advance to the next one
//   byte_o     : byte currently presented (top byte of the shift register)
//   last_o     : the presented byte is the final one of the word
module dbg_byte_serializer
    import debug_pkg::*;
#(
    parameter int DATA_W = DBG_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              shift_i,
    output logic [7:0]        byte_o,
    output logic              last_o
);

    localparam int CNT_W = $clog2(DATA_W / 8 + 1);
    localparam logic [CNT_W-1:0] NBYTES = CNT_W'(DATA_W / 8);

    logic [DATA_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        if (load_i) begin
            shift_d = data_i;
            cnt_d   = NBYTES;
        end else if (shift_i) begin
            shift_d = {shift_q[DATA_W-9:0], 8'h00};
            cnt_d   = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

    assign byte_o = shift_q[DATA_W-1 -: 8];
    assign last_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/regfile_debug_dumper.sv
// Sweeps every architectural register through the register file's debug
// read port and streams each word, MSB byte first, to the debug UART over
// a valid/ready byte handshake.
//   clk, rst       : system clock, asynchronous active-high reset
//   start          : dump request, honoured only in IDLE
//   debug_on       : register-file debug read enable
//   read_regDebug  : debug read address
//   reg_debug      : debug read data (register file reads on negedge)
//   tx_data/valid  : byte stream to UART; tx_ready accepts a byte
//   busy           : dump in progress
//   done           : one-cycle pulse after the final byte is accepted
// Build option: define DUMP_CHECKSUM_EN to append one byte holding the XOR
// of every dumped byte after the last register.
module regfile_debug_dumper
    import debug_pkg::*;
#(
    parameter int NUM_REGS = DBG_NUM_REGS,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = DBG_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              debug_on,
    output logic [ADDR_W-1:0] read_regDebug,
    input  logic [DATA_W-1:0] reg_debug,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

    dbg_state_e        state_q;
    logic [ADDR_W-1:0] addr_q;
    logic              debug_on_q;
    logic              tx_valid_q;
    logic              busy_q;
    logic              done_q;

    logic [7:0]        ser_byte;
    logic              ser_last;
    logic              ser_load;
    logic              ser_shift;

    assign ser_load  = (state_q == LOAD);
    assign ser_shift = (state_q == SEND) && tx_valid_q && tx_ready;

    dbg_byte_serializer #(
        .DATA_W (DATA_W)
    ) u_ser (
        .clk     (clk),
        .rst     (rst),
        .load_i  (ser_load),
        .data_i  (reg_debug),
        .shift_i (ser_shift),
        .byte_o  (ser_byte),
        .last_o  (ser_last)
    );

`ifdef DUMP_CHECKSUM_EN
    logic [7:0] cksum_q;
    assign tx_data = (state_q == CKSUM) ? cksum_q : ser_byte;
`else
    assign tx_data = ser_byte;
`endif

    // tx_valid_q is always 1 in SEND/CKSUM, so tx_ready alone marks a transfer there.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            debug_on_q <= 1'b0;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
            cksum_q    <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q    <= SET_ADDR;
                        addr_q     <= '0;
                        debug_on_q <= 1'b1;
                        busy_q     <= 1'b1;
`ifdef DUMP_CHECKSUM_EN
                        cksum_q    <= '0;
`endif
                    end
                end
                SET_ADDR: state_q <= WAIT_RD;
                WAIT_RD:  state_q <= LOAD;
                LOAD: begin
                    state_q    <= SEND;
                    tx_valid_q <= 1'b1;
                end
                SEND: begin
                    if (tx_ready) begin
`ifdef DUMP_CHECKSUM_EN
                        cksum_q <= cksum_q ^ ser_byte;
`endif
                        if (ser_last) begin
                            if (addr_q != LAST_ADDR) begin
                                addr_q     <= addr_q + ADDR_W'(1);
                                state_q    <= SET_ADDR;
                                tx_valid_q <= 1'b0;
                            end else begin
                                debug_on_q <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
                                state_q    <= CKSUM;
`else
                                state_q    <= DONE;
                                tx_valid_q <= 1'b0;
                                busy_q     <= 1'b0;
                                done_q     <= 1'b1;
`endif
                            end
                        end
                    end
                end
                CKSUM: begin
                    if (tx_ready) begin
                        state_q    <= DONE;
                        tx_valid_q <= 1'b0;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign debug_on      = debug_on_q;
    assign read_regDebug = addr_q;
    assign tx_valid      = tx_valid_q;
    assign busy          = busy_q;
    assign done          = done_q;

endmodule

// File: tb/tb_regfile_debug_dumper.sv
module tb_regfile_debug_dumper;

    localparam int NR = 32;
    localparam int NB = NR * 4;
`ifdef DUMP_CHECKSUM_EN
    localparam int EXP_BYTES = NB + 1;
`else
    localparam int EXP_BYTES = NB;
`endif

    logic        clk;
    logic        rst;
    logic        start;
    logic        debug_on;
    logic [4:0]  read_regDebug;
    logic [31:0] reg_debug;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;
    logic        done;

    logic [31:0] mem [NR];
    logic [7:0]  cap [$];
    logic [7:0]  exp_q [$];
    int          done_cnt;
    bit          rand_mode;
    int          n_pass;
    int          n_total;

    regfile_debug_dumper dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .debug_on      (debug_on),
        .read_regDebug (read_regDebug),
        .reg_debug     (reg_debug),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .busy          (busy),
        .done          (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Register file model: debug read on the falling edge.
    initial reg_debug = '0;
    always @(negedge clk) if (debug_on) reg_debug <= mem[read_regDebug];

    always @(negedge clk) begin
        if (!rst && tx_valid && tx_ready) cap.push_back(tx_data);
        if (!rst && done) done_cnt++;
    end

    always @(posedge clk) begin
        #1;
        if (rand_mode) tx_ready = 1'($urandom_range(0, 1));
    end

    task automatic load_image();
        for (int i = 0; i < NR; i++) mem[i] = {8'(i), 8'hC3, 8'(255 - i), 8'(i * 7)};
        mem[0]  = 32'h0000_0001;
        mem[21] = 32'h0000_0010;
        mem[31] = 32'h0000_002A;
    endtask

    task automatic build_exp();
        logic [7:0] x;
        x = 8'h00;
        exp_q.delete();
        for (int r = 0; r < NR; r++)
            for (int b = 0; b < 4; b++) begin
                exp_q.push_back(mem[r][31-8*b -: 8]);
                x = x ^ mem[r][31-8*b -: 8];
            end
`ifdef DUMP_CHECKSUM_EN
        exp_q.push_back(x);
`endif
    endtask

    function automatic int first_mism();
        for (int i = 0; i < exp_q.size(); i++)
            if (i >= cap.size() || cap[i] !== exp_q[i]) return i;
        if (cap.size() != exp_q.size()) return exp_q.size();
        return -1;
    endfunction

    task automatic clear_caps();
        cap.delete();
        done_cnt = 0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit to);
        to = 1'b1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                to = 1'b0;
                break;
            end
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; tx_ready = 1'b1; rand_mode = 1'b0;
        repeat (3) @(negedge clk);
        n_total++;
        if ({debug_on, tx_valid, busy, done} !== 4'b0000)
            $display("FAIL reset_ctrl got {dbg,vld,busy,done}=%b want 0000", {debug_on, tx_valid, busy, done});
        else n_pass++;
        n_total++;
        if (tx_data !== 8'h00 || read_regDebug !== 5'd0)
            $display("FAIL reset_data got tx_data=%h addr=%0d want 00/0", tx_data, read_regDebug);
        else n_pass++;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_total++;
        if (busy !== 1'b0 || tx_valid !== 1'b0)
            $display("FAIL idle_after_reset got busy=%b vld=%b want 0/0", busy, tx_valid);
        else n_pass++;
    endtask

    task automatic test_dump();
        bit to;
        int lat;
        load_image();
        build_exp();
        clear_caps();
        pulse_start();
        n_total++;
        if (busy !== 1'b1 || debug_on !== 1'b1 || read_regDebug !== 5'd0)
            $display("FAIL set_addr got busy=%b dbg=%b addr=%0d want 1/1/0", busy, debug_on, read_regDebug);
        else n_pass++;
        lat = 0;
        while (!tx_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        n_total++;
        if (lat !== 3) $display("FAIL first_valid_latency got %0d want 3 cycles after SET_ADDR", lat);
        else n_pass++;
        wait_done(1000, to);
        n_total++;
        if (to) $display("FAIL dump_timeout got no done want done");
        else n_pass++;
        n_total++;
        if (cap.size() !== EXP_BYTES) $display("FAIL byte_count got %0d want %0d", cap.size(), EXP_BYTES);
        else n_pass++;
        n_total++;
        if (cap.size() < NB || {cap[0], cap[1], cap[2], cap[3]} !== 32'h0000_0001)
            $display("FAIL r0_bytes got size=%0d want 00 00 00 01", cap.size());
        else n_pass++;
        n_total++;
        if (cap.size() < NB || {cap[124], cap[125], cap[126], cap[127]} !== 32'h0000_002A)
            $display("FAIL r31_bytes got size=%0d want 00 00 00 2a", cap.size());
        else n_pass++;
        n_total++;
        if (first_mism() != -1) $display("FAIL stream got mismatch at byte %0d want none", first_mism());
        else n_pass++;
        n_total++;
        if (done_cnt !== 1 || busy !== 1'b0)
            $display("FAIL done_pulse got done_cnt=%0d busy=%b want 1/0", done_cnt, busy);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        bit to;
        bit hold_ok;
        bit found;
        load_image();
        build_exp();
        clear_caps();
        pulse_start();
        found = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk);
            #1;
            if (cap.size() == 86) begin
                found = 1'b1;
                break;
            end
        end
        tx_ready = 1'b0;
        n_total++;
        if (!found || tx_valid !== 1'b1 || tx_data !== 8'h00 || read_regDebug !== 5'd21)
            $display("FAIL stall_entry got found=%b vld=%b data=%h addr=%0d want 1/1/00/21",
                     found, tx_valid, tx_data, read_regDebug);
        else n_pass++;
        hold_ok = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (tx_valid !== 1'b1 || tx_data !== 8'h00 || read_regDebug !== 5'd21) hold_ok = 1'b0;
        end
        n_total++;
        if (!hold_ok || cap.size() != 86)
            $display("FAIL stall_hold got hold_ok=%b size=%0d want 1/86", hold_ok, cap.size());
        else n_pass++;
        @(posedge clk);
        #1;
        tx_ready = 1'b1;
        wait_done(1000, to);
        n_total++;
        if (to || cap.size() < 88 || cap[86] !== 8'h00 || cap[87] !== 8'h10)
            $display("FAIL stall_release got to=%b size=%0d want bytes 00,10 at 86,87", to, cap.size());
        else n_pass++;
        n_total++;
        if (first_mism() != -1) $display("FAIL stall_stream got mismatch at byte %0d want none", first_mism());
        else n_pass++;
    endtask

    task automatic test_start_mid_dump();
        bit to;
        bit hit;
        load_image();
        build_exp();
        clear_caps();
        pulse_start();
        hit = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (read_regDebug == 5'd10) begin
                hit = 1'b1;
                break;
            end
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(1000, to);
        n_total++;
        if (!hit || to || cap.size() !== EXP_BYTES || done_cnt !== 1)
            $display("FAIL restart_ignored got hit=%b to=%b size=%0d done_cnt=%0d want 1/0/%0d/1",
                     hit, to, cap.size(), done_cnt, EXP_BYTES);
        else n_pass++;
        repeat (300) @(negedge clk);
        n_total++;
        if (cap.size() !== EXP_BYTES || done_cnt !== 1 || busy !== 1'b0)
            $display("FAIL no_second_dump got size=%0d done_cnt=%0d busy=%b want %0d/1/0",
                     cap.size(), done_cnt, busy, EXP_BYTES);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        bit to;
        bit hit;
        load_image();
        build_exp();
        clear_caps();
        pulse_start();
        hit = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (read_regDebug == 5'd5 && tx_valid) begin
                hit = 1'b1;
                break;
            end
        end
        #2 rst = 1'b1;
        #1;
        n_total++;
        if (!hit || {tx_valid, busy, debug_on} !== 3'b000)
            $display("FAIL async_abort got hit=%b {vld,busy,dbg}=%b want 1/000", hit, {tx_valid, busy, debug_on});
        else n_pass++;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        n_total++;
        if (tx_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL no_resume got vld=%b busy=%b want 0/0", tx_valid, busy);
        else n_pass++;
        clear_caps();
        pulse_start();
        wait_done(1000, to);
        n_total++;
        if (to || first_mism() != -1)
            $display("FAIL restart_from_r0 got to=%b mismatch at %0d want 0/none", to, first_mism());
        else n_pass++;
    endtask

    task automatic test_random_ready();
        bit to;
        load_image();
        build_exp();
        rand_mode = 1'b1;
        for (int run = 0; run < 3; run++) begin
            clear_caps();
            pulse_start();
            wait_done(4000, to);
            n_total++;
            if (to || first_mism() != -1 || done_cnt !== 1)
                $display("FAIL random_run%0d got to=%b mismatch at %0d done_cnt=%0d want 0/none/1",
                         run, to, first_mism(), done_cnt);
            else n_pass++;
        end
        rand_mode = 1'b0;
        @(posedge clk);
        #1;
        tx_ready = 1'b1;
    endtask

    task automatic test_checksum();
        bit to;
        for (int i = 0; i < NR; i++) mem[i] = 32'h0;
        mem[0]  = 32'h0000_0001;
        mem[31] = 32'h0000_002A;
        build_exp();
        clear_caps();
        pulse_start();
        wait_done(1000, to);
        n_total++;
        if (to || cap.size() !== EXP_BYTES)
            $display("FAIL cksum_count got to=%b size=%0d want 0/%0d", to, cap.size(), EXP_BYTES);
        else n_pass++;
`ifdef DUMP_CHECKSUM_EN
        n_total++;
        if (cap.size() < NB + 1 || cap[NB] !== 8'h2B)
            $display("FAIL cksum_byte got size=%0d want byte 2b at %0d", cap.size(), NB);
        else n_pass++;
`endif
        n_total++;
        if (first_mism() != -1) $display("FAIL cksum_stream got mismatch at byte %0d want none", first_mism());
        else n_pass++;
    endtask

    initial begin
        n_pass   = 0;
        n_total  = 0;
        done_cnt = 0;
        test_reset();
        test_dump();
        test_backpressure();
        test_start_mid_dump();
        test_reset_mid();
        test_random_ready();
        test_checksum();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
